// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider with shadowed divide values and a global phase restart.
// Optional per-period tick outputs are built only when PROG_CLOCK_DIVIDER_TICK_EN is defined.
module prog_clock_divider #(
  parameter int CH          = 4,
  parameter int WIDTH       = 32,
  parameter int DEFAULT_DIV = 100000,
  localparam int AW         = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             i_CLK,
  input  logic             i_RST_N,
  input  logic [CH-1:0]    i_EN,
  input  logic             i_SYNC,
  input  logic             i_WE,
  input  logic [AW-1:0]    i_ADDR,
  input  logic [WIDTH-1:0] i_DIV,
  output logic [CH-1:0]    o_CLK,
  output logic [CH-1:0]    o_TICK
);

  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] v);
    return (v < WIDTH'(2)) ? WIDTH'(2) : v;
  endfunction

  localparam logic [WIDTH-1:0] RST_DIV = clamp_div(WIDTH'(DEFAULT_DIV));

  logic [WIDTH-1:0] cnt_q [CH];
  logic [WIDTH-1:0] cnt_d [CH];
  logic [WIDTH-1:0] div_q [CH];
  logic [WIDTH-1:0] div_d [CH];
  logic [WIDTH-1:0] shd_q [CH];
  logic [WIDTH-1:0] shd_d [CH];
  logic [WIDTH-1:0] inc   [CH];
  logic [WIDTH-1:0] half  [CH];
  logic [CH-1:0]    wrap;
  logic [CH-1:0]    clk_d;

  // ">=" rather than "==" so a counter left beyond a shrunken D (loaded while
  // disabled) wraps at once instead of running to 2^WIDTH.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      inc[c]   = cnt_q[c] + WIDTH'(1);
      half[c]  = (div_q[c] >> 1) + WIDTH'(div_q[c][0]);
      wrap[c]  = (cnt_q[c] >= div_q[c] - WIDTH'(1));
      cnt_d[c] = cnt_q[c];
      clk_d[c] = o_CLK[c];
      div_d[c] = div_q[c];
      shd_d[c] = shd_q[c];
      if (i_SYNC) begin
        cnt_d[c] = '0;
        clk_d[c] = 1'b0;
        div_d[c] = shd_q[c];
      end else if (!i_EN[c]) begin
        div_d[c] = shd_q[c];
      end else if (wrap[c]) begin
        cnt_d[c] = '0;
        clk_d[c] = 1'b0;
        div_d[c] = shd_q[c];
      end else begin
        cnt_d[c] = inc[c];
        clk_d[c] = (inc[c] >= half[c]);
      end
      if (i_WE && (int'(i_ADDR) == c)) shd_d[c] = clamp_div(i_DIV);
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      for (int c = 0; c < CH; c++) begin
        cnt_q[c] <= '0;
        div_q[c] <= RST_DIV;
        shd_q[c] <= RST_DIV;
      end
      o_CLK <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        cnt_q[c] <= cnt_d[c];
        div_q[c] <= div_d[c];
        shd_q[c] <= shd_d[c];
      end
      o_CLK <= clk_d;
    end
  end

`ifdef PROG_CLOCK_DIVIDER_TICK_EN
  logic [CH-1:0] tick_d;

  always_comb begin
    tick_d = '0;
    for (int c = 0; c < CH; c++) tick_d[c] = !i_SYNC && i_EN[c] && wrap[c];
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) o_TICK <= '0;
    else          o_TICK <= tick_d;
  end
`else
  assign o_TICK = '0;
`endif

endmodule

// File: tb/tb_prog_clock_divider.sv
// Randomized self-checking bench for prog_clock_divider against a period-level reference model.
// Runs in both builds; tick expectations follow PROG_CLOCK_DIVIDER_TICK_EN.
module tb_prog_clock_divider;
  localparam int CH    = 4;
  localparam int WIDTH = 8;
  localparam int DDIV  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [CH-1:0]    en;
  logic             sync;
  logic             we;
  logic [1:0]       addr;
  logic [WIDTH-1:0] div;
  logic [CH-1:0]    o_clk;
  logic [CH-1:0]    o_tick;

  int checks = 0;
  int failures = 0;

  // Reference model: position in period, active and pending period lengths.
  int m_pos [CH];
  int m_per [CH];
  int m_pend[CH];
  bit m_lvl [CH];
  bit m_tck [CH];

  prog_clock_divider #(.CH(CH), .WIDTH(WIDTH), .DEFAULT_DIV(DDIV)) dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_EN(en), .i_SYNC(sync), .i_WE(we),
    .i_ADDR(addr), .i_DIV(div), .o_CLK(o_clk), .o_TICK(o_tick)
  );

  always #5 clk = ~clk;

  function automatic int clampi(int v);
    return (v < 2) ? 2 : v;
  endfunction

  function automatic logic [CH-1:0] exp_clk();
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = m_lvl[c];
    return v;
  endfunction

  function automatic logic [CH-1:0] exp_tick();
    logic [CH-1:0] v;
    v = '0;
`ifdef PROG_CLOCK_DIVIDER_TICK_EN
    for (int c = 0; c < CH; c++) v[c] = m_tck[c];
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_pos[c] = 0; m_per[c] = DDIV; m_pend[c] = DDIV; m_lvl[c] = 0; m_tck[c] = 0;
    end
  endtask

  // Low for the first ceil(P/2) positions of a period, high for the rest.
  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      m_tck[c] = 0;
      if (sync) begin
        m_pos[c] = 0; m_lvl[c] = 0; m_per[c] = m_pend[c];
      end else if (!en[c]) begin
        m_per[c] = m_pend[c];
      end else if (m_pos[c] + 1 >= m_per[c]) begin
        m_pos[c] = 0; m_lvl[c] = 0; m_tck[c] = 1; m_per[c] = m_pend[c];
      end else begin
        m_pos[c] = m_pos[c] + 1;
        m_lvl[c] = (m_pos[c] >= (m_per[c] + 1) / 2);
      end
    end
    if (we) m_pend[addr] = clampi(int'(div));
  endtask

  // Advance one clock; returns at the following falling edge.
  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = '1; sync = 0; we = 0; addr = 0; div = 0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (o_clk !== '0 || o_tick !== '0) begin
      failures++; $display("FAIL reset_state clk=%b tick=%b want 0000/0000", o_clk, o_tick);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      logic [CH-1:0] lit_clk, lit_tick;
      advance();
      lit_clk  = ((k % 4) >= 2) ? '1 : '0;
      lit_tick = '0;
`ifdef PROG_CLOCK_DIVIDER_TICK_EN
      lit_tick = ((k % 4) == 0) ? '1 : '0;
`endif
      checks++;
      if (o_clk !== lit_clk || o_tick !== lit_tick) begin
        failures++;
        $display("FAIL div4_pattern k=%0d clk=%b tick=%b want %b/%b", k, o_clk, o_tick, lit_clk, lit_tick);
      end
    end
  endtask

  task automatic test_write_mid();
    advance();
    we = 1; addr = 2'd1; div = 8'd5;
    advance();
    we = 0;
    for (int k = 0; k < 20; k++) begin
      advance();
      checks++;
      if (o_clk !== exp_clk() || o_tick !== exp_tick()) begin
        failures++;
        $display("FAIL write_mid k=%0d clk=%b tick=%b want %b/%b", k, o_clk, o_tick, exp_clk(), exp_tick());
      end
    end
  endtask

  task automatic test_clamp();
    we = 1; addr = 2'd3; div = 8'd0;
    advance();
    div = 8'd1;
    advance();
    we = 0;
    for (int k = 0; k < 12; k++) begin
      advance();
      checks++;
      if (o_clk !== exp_clk() || o_tick !== exp_tick()) begin
        failures++;
        $display("FAIL clamp k=%0d clk=%b tick=%b want %b/%b", k, o_clk, o_tick, exp_clk(), exp_tick());
      end
    end
    advance();
    checks++;
    if (m_per[3] != 2 || o_clk[3] === exp_clk_prev3()) begin
      failures++; $display("FAIL clamp_toggle per=%0d clk3=%b want per 2 toggling", m_per[3], o_clk[3]);
    end
  endtask

  bit prev3;
  always @(posedge clk) prev3 <= o_clk[3];
  function automatic bit exp_clk_prev3();
    return prev3;
  endfunction

  task automatic test_disable();
    int guard;
    logic held;
    guard = 0;
    while (m_pos[2] != 1 && guard < 16) begin
      advance(); guard++;
    end
    checks++;
    if (m_pos[2] != 1) begin
      failures++; $display("FAIL disable_align pos=%0d want 1 within 16 cycles", m_pos[2]);
    end
    held = o_clk[2];
    en[2] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      advance();
      checks++;
      if (o_clk[2] !== held || o_tick[2] !== 1'b0 || o_clk !== exp_clk() || o_tick !== exp_tick()) begin
        failures++;
        $display("FAIL disable_hold k=%0d clk=%b tick=%b want %b/%b", k, o_clk, o_tick, exp_clk(), exp_tick());
      end
    end
    en[2] = 1'b1;
    advance();
    checks++;
    if (o_clk[2] !== 1'b1 || m_pos[2] != 2) begin
      failures++; $display("FAIL disable_resume clk2=%b pos=%0d want 1 at pos 2", o_clk[2], m_pos[2]);
    end
  endtask

  task automatic test_sync();
    we = 1; addr = 2'd0; div = 8'd3; sync = 1;
    advance();
    we = 0; sync = 0;
    checks++;
    if (o_clk !== '0 || o_tick !== '0) begin
      failures++; $display("FAIL sync_align clk=%b tick=%b want 0000/0000", o_clk, o_tick);
    end
    for (int k = 0; k < 16; k++) begin
      advance();
      checks++;
      if (o_clk !== exp_clk() || o_tick !== exp_tick()) begin
        failures++;
        $display("FAIL sync_follow k=%0d clk=%b tick=%b want %b/%b", k, o_clk, o_tick, exp_clk(), exp_tick());
      end
    end
  endtask

  task automatic test_max_div();
    int errs;
    errs = 0;
    we = 1; addr = 2'd1; div = 8'hFF;
    advance();
    we = 0; sync = 1;
    advance();
    sync = 0;
    for (int k = 0; k < 540; k++) begin
      advance();
      if (o_clk !== exp_clk() || o_tick !== exp_tick()) errs++;
    end
    checks++;
    if (errs != 0) begin
      failures++; $display("FAIL max_div mismatching_cycles=%0d want 0", errs);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int k = 0; k < 2000; k++) begin
      we   = ($urandom_range(0, 7) == 0);
      addr = 2'($urandom_range(0, 3));
      div  = 8'($urandom_range(0, 11));
      sync = ($urandom_range(0, 60) == 0);
      for (int c = 0; c < CH; c++) en[c] = ($urandom_range(0, 9) != 0);
      advance();
      if (o_clk !== exp_clk() || o_tick !== exp_tick()) begin
        errs++;
        if (errs < 5)
          $display("FAIL random k=%0d clk=%b tick=%b want %b/%b", k, o_clk, o_tick, exp_clk(), exp_tick());
      end
    end
    checks++;
    if (errs != 0) failures++;
    we = 0; sync = 0; en = '1;
  endtask

  task automatic test_async_reset();
    int guard;
    guard = 0;
    while (o_clk[0] !== 1'b1 && guard < 40) begin
      advance(); guard++;
    end
    checks++;
    if (o_clk[0] !== 1'b1) begin
      failures++; $display("FAIL async_wait clk0=%b want 1 within 40 cycles", o_clk[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_clk !== '0 || o_tick !== '0) begin
      failures++; $display("FAIL async_reset clk=%b tick=%b want 0000/0000", o_clk, o_tick);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (o_clk !== '0 || o_tick !== '0) begin
      failures++; $display("FAIL reset_hold clk=%b tick=%b want 0000/0000", o_clk, o_tick);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      advance();
      checks++;
      if (o_clk !== exp_clk() || o_tick !== exp_tick()) begin
        failures++;
        $display("FAIL post_reset k=%0d clk=%b tick=%b want %b/%b", k, o_clk, o_tick, exp_clk(), exp_tick());
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_mid();
    test_clamp();
    test_disable();
    test_sync();
    test_max_div();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_clock_divider.md
PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent divider channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 32: divide-value and counter width.
REQ-003 SHALL have parameter DEFAULT_DIV, default 100000: per-channel divide value after reset (1 kHz from 100 MHz).
REQ-004 SHALL have port i_CLK, input, 1: single system clock; all logic on rising edge.
REQ-005 SHALL have port i_RST_N, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port i_EN, input, CH: per-channel run enable.
REQ-007 SHALL have port i_SYNC, input, 1: global phase-restart pulse.
REQ-008 SHALL have port i_WE, input, 1: divide-value write strobe.
REQ-009 SHALL have port i_ADDR, input, max(1,clog2(CH)): channel select for write.
REQ-010 SHALL have port i_DIV, input, WIDTH: divide value (full period, in i_CLK cycles).
REQ-011 SHALL have port o_CLK, output, CH: registered divided clock per channel.
REQ-012 SHALL have port o_TICK, output, CH: registered one-cycle pulse per completed period.

Function
REQ-013 Each channel SHALL hold active value D, shadow value S, and counter cnt (0..D-1).
REQ-014 A write (i_WE=1, i_ADDR<CH) SHALL store i_DIV into S of the addressed channel; i_ADDR>=CH SHALL be ignored.
REQ-015 Values 0 and 1 SHALL be clamped to 2 when stored into S.
REQ-016 Enabled channel: cnt SHALL increment each cycle; at cnt==D-1 it SHALL wrap to 0, pulse o_TICK for that cycle, and load D<=S.
REQ-017 o_CLK SHALL be 0 while cnt < ceil(D/2) and 1 for cnt in [ceil(D/2), D-1], registered with the same next-state as cnt (low phase ceil(D/2), high phase floor(D/2) cycles).
REQ-018 Disabled channel (i_EN=0): cnt and o_CLK SHALL hold, o_TICK SHALL be 0, D SHALL load S every cycle.
REQ-019 i_SYNC=1 SHALL, in the same edge, set all cnt to 0, all o_CLK to 0, all o_TICK to 0, and all D<=S regardless of i_EN.
REQ-020 i_SYNC and a write in the same cycle: sync SHALL load the pre-write S; the new value SHALL take effect at the next wrap, disable, or sync.
REQ-021 A write landing on the wrap cycle of its channel SHALL NOT be used for that wrap; D<=old S.
REQ-022 Channels SHALL be fully independent except for shared i_SYNC and write bus.
REQ-023 Counter compare SHALL be unsigned WIDTH-bit; D=2^WIDTH-1 SHALL operate without overflow.

Reset
REQ-024 While i_RST_N=0: all cnt=0, o_CLK=0, o_TICK=0, D=S=DEFAULT_DIV (clamped per REQ-015).
REQ-025 Reset assertion SHALL take effect asynchronously mid-period; release SHALL be synchronous to i_CLK, first count on the first edge after release.

Configuration
REQ-026 Macro PROG_CLOCK_DIVIDER_TICK_EN defined: o_TICK SHALL behave per REQ-016/018/019.
REQ-027 Macro undefined: o_TICK SHALL be constant 0 and tick logic SHALL be omitted; o_CLK behaviour unchanged.

Verification
REQ-028 Reset, CH=4, DEFAULT_DIV=4, all i_EN=1 -> each o_CLK pattern 0,0,1,1 repeating; o_TICK high every 4th cycle, on cnt 3->0.
REQ-029 Write i_ADDR=1, i_DIV=5 mid-period -> channel 1 finishes current 4-cycle period, then 0,0,0,1,1 repeating; other channels unchanged.
REQ-030 Write i_DIV=0 then i_DIV=1 -> channel runs with D=2: o_CLK toggles every cycle, o_TICK every 2nd cycle.
REQ-031 Deassert i_EN[2] for 7 cycles at cnt=1 -> o_CLK[2] frozen, o_TICK[2]=0; resumes from cnt=2.
REQ-032 Channels at different phases, pulse i_SYNC with a simultaneous write to channel 0 -> all o_CLK=0, cnt=0 next cycle and phase-aligned; channel 0 adopts new value only after its next wrap.
REQ-033 Assert i_RST_N=0 between clock edges mid-high-phase -> o_CLK/o_TICK go 0 immediately; macro undefined build -> o_TICK stays 0 throughout.
